// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven controller for a 4-bit counter.
// It accepts one job per valid/ready handshake, loads the counter, steps it at
// a prescaled rate in binary-up, BCD-up or binary-down mode, and then reports
// completion (Done) or a rejected command (Err).
module counter_sequencer #(
  parameter int PRESCALE = 1,
  parameter int STEP_W   = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic [1:0]        Cmd_Mode,
  input  logic [3:0]        Cmd_Start,
  input  logic [STEP_W-1:0] Cmd_Steps,
  input  logic              Abort,
  output logic [3:0]        Q,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0]        MODE_BIN_UP = 2'b00;
  localparam logic [1:0]        MODE_BCD_UP = 2'b01;
  localparam logic [1:0]        MODE_BIN_DN = 2'b10;
  localparam logic [7:0]        PRE_LAST    = 8'(PRESCALE - 1);
  localparam logic [STEP_W-1:0] REM_ONE     = STEP_W'(1);
  localparam logic [STEP_W-1:0] REM_ZERO    = '0;

  state_t            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [1:0]        mode_q, mode_d;
  logic [STEP_W-1:0] remSteps_q, remSteps_d;
  logic [7:0]        preCnt_q, preCnt_d;
  logic              busy_q, done_q, err_q;
  logic              errPulse_d;
  logic              accept;
  logic              illegalCmd;
  logic [3:0]        stepValue;

  // A command is taken only in IDLE, and Abort blocks acceptance there too.
  assign Cmd_Ready  = (state_q == ST_IDLE) && !Abort;
  assign accept     = Cmd_Valid && Cmd_Ready;
  assign illegalCmd = (Cmd_Mode == 2'b11) ||
                      ((Cmd_Mode == MODE_BCD_UP) && (Cmd_Start > 4'd9));

  assign Q    = count_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Err  = err_q;

  // Next counter value for one step in the latched mode, wrapping at each limit.
  always_comb begin
    stepValue = count_q;
    case (mode_q)
      MODE_BIN_UP: stepValue = count_q + 4'd1;
      MODE_BCD_UP: stepValue = (count_q == 4'd9) ? 4'd0 : count_q + 4'd1;
      MODE_BIN_DN: stepValue = count_q - 4'd1;
      default:     stepValue = count_q;
    endcase
  end

  // Next-state logic: command acceptance, prescaled stepping, abort and completion.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mode_d     = mode_q;
    remSteps_d = remSteps_q;
    preCnt_d   = preCnt_q;
    errPulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (illegalCmd) begin
            errPulse_d = 1'b1;
          end else begin
            count_d    = Cmd_Start;
            mode_d     = Cmd_Mode;
            remSteps_d = Cmd_Steps;
            preCnt_d   = 8'd0;
            state_d    = (Cmd_Steps == REM_ZERO) ? ST_DONE : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (Abort) begin
          preCnt_d = 8'd0;
          state_d  = ST_IDLE;
        end else if (preCnt_q == PRE_LAST) begin
          preCnt_d   = 8'd0;
          count_d    = stepValue;
          remSteps_d = remSteps_q - REM_ONE;
          if (remSteps_q == REM_ONE) begin
            state_d = ST_DONE;
          end
        end else begin
          preCnt_d = preCnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; status flags are registered from the next state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      count_q    <= 4'd0;
      mode_q     <= MODE_BIN_UP;
      remSteps_q <= REM_ZERO;
      preCnt_q   <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mode_q     <= mode_d;
      remSteps_q <= remSteps_d;
      preCnt_q   <= preCnt_d;
      busy_q     <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);
      err_q      <= errPulse_d;
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer: two instances (PRESCALE=1 and PRESCALE=3)
// share stimulus, with 'sel' choosing which one receives Cmd_Valid/Abort and
// whose outputs are observed. Expected Q comes from closed-form modular
// arithmetic on the start value and the number of elapsed steps.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmdValid;
  logic       abort;
  logic       sel;
  logic [1:0] mode;
  logic [3:0] start;
  logic [7:0] steps;

  logic       valid1, abort1, ready1, busy1, done1, err1;
  logic       valid3, abort3, ready3, busy3, done3, err3;
  logic [3:0] q1, q3;

  logic       ready, busy, done, err;
  logic [3:0] q;

  logic [3:0] lastQ [2];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  // Only the selected instance sees the handshake and abort.
  assign valid1 = cmdValid && !sel;
  assign abort1 = abort && !sel;
  assign valid3 = cmdValid && sel;
  assign abort3 = abort && sel;

  assign ready = sel ? ready3 : ready1;
  assign busy  = sel ? busy3  : busy1;
  assign done  = sel ? done3  : done1;
  assign err   = sel ? err3   : err1;
  assign q     = sel ? q3     : q1;

  counter_sequencer #(.PRESCALE(1), .STEP_W(8)) dut1 (
    .Clk(clk), .Rst(rst), .Cmd_Valid(valid1), .Cmd_Ready(ready1),
    .Cmd_Mode(mode), .Cmd_Start(start), .Cmd_Steps(steps), .Abort(abort1),
    .Q(q1), .Busy(busy1), .Done(done1), .Err(err1)
  );

  counter_sequencer #(.PRESCALE(3), .STEP_W(8)) dut3 (
    .Clk(clk), .Rst(rst), .Cmd_Valid(valid3), .Cmd_Ready(ready3),
    .Cmd_Mode(mode), .Cmd_Start(start), .Cmd_Steps(steps), .Abort(abort3),
    .Q(q3), .Busy(busy3), .Done(done3), .Err(err3)
  );

  // Counter value after n steps from s, straight from the wrap rules.
  function automatic logic [3:0] expQ(input logic [1:0] m, input logic [3:0] s, input int n);
    int v;
    case (m)
      2'b00:   v = (int'(s) + n) % 16;
      2'b01:   v = (int'(s) + n) % 10;
      2'b10:   v = ((int'(s) - n) % 16 + 16) % 16;
      default: v = int'(s);
    endcase
    return 4'(v);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one command to the selected instance and follow it to completion.
  // abortAt>0 raises Abort so that it is sampled at edge k+abortAt.
  task automatic do_job(input logic [1:0] m, input logic [3:0] s, input int n, input int abortAt);
    int         p;
    int         idx;
    int         endT;
    logic [3:0] eq;
    bit         illegal;
    p       = sel ? 3 : 1;
    idx     = sel ? 1 : 0;
    endT    = n * p;
    illegal = (m == 2'b11) || (m == 2'b01 && s > 4'd9);
    mode = m; start = s; steps = 8'(n); cmdValid = 1'b1;
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_before_accept: got %b expected 1", ready);
    end
    tick;
    cmdValid = 1'b0;
    if (illegal) begin
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || q !== lastQ[idx]) begin
        bad++;
        $display("[TB] FAIL illegal_cmd m=%0d s=%0d: got err=%b busy=%b done=%b q=%0d expected err=1 busy=0 done=0 q=%0d",
                 m, s, err, busy, done, q, lastQ[idx]);
      end
      tick;
      total++;
      if (err !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || q !== lastQ[idx]) begin
        bad++;
        $display("[TB] FAIL illegal_after: got err=%b ready=%b busy=%b q=%0d expected err=0 ready=1 busy=0 q=%0d",
                 err, ready, busy, q, lastQ[idx]);
      end
      return;
    end
    for (int t = 0; t <= endT; t++) begin
      eq = expQ(m, s, t / p);
      total++;
      if (q !== eq || busy !== (t < endT) || done !== (t == endT) || err !== 1'b0) begin
        bad++;
        $display("[TB] FAIL job_cycle m=%0d s=%0d n=%0d p=%0d t=%0d: got q=%0d busy=%b done=%b err=%b expected q=%0d busy=%b done=%b err=0",
                 m, s, n, p, t, q, busy, done, err, eq, (t < endT), (t == endT));
      end
      if (abortAt > 0 && t == abortAt - 1) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        #1;
        eq = expQ(m, s, (abortAt - 1) / p);
        total++;
        if (q !== eq || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || ready !== 1'b1) begin
          bad++;
          $display("[TB] FAIL abort m=%0d s=%0d n=%0d p=%0d at=%0d: got q=%0d busy=%b done=%b err=%b ready=%b expected q=%0d busy=0 done=0 err=0 ready=1",
                   m, s, n, p, abortAt, q, busy, done, err, ready, eq);
        end
        lastQ[idx] = eq;
        return;
      end
      if (t < endT) tick;
    end
    lastQ[idx] = expQ(m, s, n);
    tick;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1 || q !== lastQ[idx]) begin
      bad++;
      $display("[TB] FAIL job_idle_after: got done=%b busy=%b ready=%b q=%0d expected done=0 busy=0 ready=1 q=%0d",
               done, busy, ready, q, lastQ[idx]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmdValid = 1'b0; abort = 1'b0; sel = 1'b0;
    mode = 2'b00; start = 4'd0; steps = 8'd0;
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      total++;
      if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL reset sel=%0d: got q=%0d busy=%b done=%b err=%b ready=%b expected 0 0 0 0 1",
                 i, q, busy, done, err, ready);
      end
    end
    sel = 1'b0;
    lastQ[0] = 4'd0;
    lastQ[1] = 4'd0;
  endtask

  task automatic test_binary_up;
    sel = 1'b0;
    do_job(2'b00, 4'd14, 3, 0);
  endtask

  task automatic test_bcd;
    sel = 1'b0;
    do_job(2'b01, 4'd8, 3, 0);
    do_job(2'b01, 4'd12, 3, 0);
  endtask

  task automatic test_down_and_reserved;
    sel = 1'b0;
    do_job(2'b10, 4'd1, 3, 0);
    do_job(2'b11, 4'd5, 3, 0);
  endtask

  task automatic test_prescale;
    sel = 1'b1;
    do_job(2'b00, 4'd0, 2, 0);
    do_job(2'b10, 4'd0, 1, 0);
    sel = 1'b0;
  endtask

  task automatic test_zero_steps;
    sel = 1'b0;
    do_job(2'b00, 4'd5, 0, 0);
  endtask

  task automatic test_abort;
    sel = 1'b0;
    do_job(2'b00, 4'd3, 10, 2);
    sel = 1'b1;
    do_job(2'b01, 4'd7, 4, 6);
    sel = 1'b0;
    // Abort in IDLE only blocks acceptance.
    abort = 1'b1; cmdValid = 1'b1; mode = 2'b00; start = 4'd11; steps = 8'd2;
    #1;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_idle_ready: got %b expected 0", ready);
    end
    tick;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || q !== lastQ[0]) begin
      bad++;
      $display("[TB] FAIL abort_idle_hold: got busy=%b done=%b err=%b q=%0d expected 0 0 0 q=%0d",
               busy, done, err, q, lastQ[0]);
    end
    abort = 1'b0; cmdValid = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    sel = 1'b0;
    mode = 2'b00; start = 4'd7; steps = 8'd8; cmdValid = 1'b1;
    tick;
    cmdValid = 1'b0;
    tick;
    tick;
    total++;
    if (busy !== 1'b1 || q !== 4'd9) begin
      bad++;
      $display("[TB] FAIL pre_reset_run: got busy=%b q=%0d expected busy=1 q=9", busy, q);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_mid_run: got q=%0d busy=%b done=%b ready=%b expected 0 0 0 1",
               q, busy, done, ready);
    end
    lastQ[0] = 4'd0;
    lastQ[1] = 4'd0;
  endtask

  task automatic test_back_to_back;
    sel = 1'b0;
    mode = 2'b00; start = 4'd2; steps = 8'd2; cmdValid = 1'b1;
    tick;
    start = 4'd9; steps = 8'd1;
    for (int t = 0; t <= 2; t++) begin
      total++;
      if (q !== 4'(2 + t) || busy !== (t < 2) || done !== (t == 2) || ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL held_valid t=%0d: got q=%0d busy=%b done=%b ready=%b expected q=%0d busy=%b done=%b ready=0",
                 t, q, busy, done, ready, 2 + t, (t < 2), (t == 2));
      end
      tick;
    end
    total++;
    if (ready !== 1'b1 || q !== 4'd4 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL held_idle: got ready=%b q=%0d busy=%b expected 1 4 0", ready, q, busy);
    end
    tick;
    cmdValid = 1'b0;
    total++;
    if (q !== 4'd9 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL second_accept: got q=%0d busy=%b expected 9 1", q, busy);
    end
    tick;
    total++;
    if (q !== 4'd10 || done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL second_done: got q=%0d done=%b busy=%b expected 10 1 0", q, done, busy);
    end
    tick;
    lastQ[0] = 4'd10;
  endtask

  task automatic test_random;
    logic [1:0] m;
    logic [3:0] s;
    int         n;
    int         p;
    int         ab;
    for (int i = 0; i < 30; i++) begin
      sel = 1'($urandom_range(0, 1));
      p   = sel ? 3 : 1;
      m   = 2'($urandom_range(0, 3));
      s   = 4'($urandom_range(0, 15));
      n   = int'($urandom_range(0, 6));
      ab  = 0;
      if (n > 0 && $urandom_range(0, 3) == 0)
        ab = int'($urandom_range(1, n * p));
      do_job(m, s, n, ab);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_binary_up;
    test_bcd;
    test_down_and_reserved;
    test_prescale;
    test_zero_steps;
    test_abort;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
